// File: rtl/fp_double.sv
// Shared IEEE-754 binary64 definitions: operand type and exponent field constants.
package fp_double;
  typedef logic [63:0] double;
  localparam int unsigned BIAS     = 1023;
  localparam logic [10:0] EXP_ONES = 11'd2047;
endpackage

// File: rtl/from_double.sv
// Serial binary64 -> signed fixed-point converter: shifts the significand one place per
// cycle, rounds to nearest (ties away from zero) and saturates out-of-range values.
// Handshake: an operand moves when in_valid && in_ready; a result moves when out_valid && out_ready.
module from_double
  import fp_double::*;
#(
  parameter int N_BITS_INT  = 32,
  parameter int N_BITS_FRAC = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  double                                 in_num,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [N_BITS_INT+N_BITS_FRAC-1:0] out_num,
  output logic                                  overflow,
  output logic                                  invalid,
  output logic [1:0]                            state_dbg
);
  localparam int W      = N_BITS_INT + N_BITS_FRAC;
  localparam int WR     = ((W > 53) ? W : 53) + 2;
  localparam logic signed [15:0] FRAC_S = 16'(N_BITS_FRAC);
  localparam logic signed [15:0] SAT_E  = 16'(N_BITS_INT - 1);
  localparam logic [WR-1:0] POS_LIM = WR'(1) << (W - 1);
  localparam logic [W-1:0]  SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SAT_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t          state, state_nxt;
  logic [5:0]      cnt;
  logic [WR-1:0]   mag;
  logic            guard, sign_q, shl, shr;

  logic [10:0]        exp_f;
  logic [51:0]        man_f;
  logic signed [15:0] e_unb, sh;
  logic [15:0]        sh_abs;
  logic [5:0]         cnt_load;
  logic               is_zero, is_nan, is_sat, special;
  logic [WR-1:0]      rnd;

  // Operand decode, only consumed on the accepting edge.
  always_comb begin
    exp_f    = in_num[62:52];
    man_f    = in_num[51:0];
    e_unb    = $signed({5'b0, exp_f}) - $signed(16'(BIAS));
    sh       = e_unb + FRAC_S - 16'sd52;
    sh_abs   = sh[15] ? 16'(-sh) : 16'(sh);
    cnt_load = (sh_abs == 16'd0) ? 6'd1 : (sh_abs > 16'd55) ? 6'd55 : 6'(sh_abs);
    is_zero  = (exp_f == 11'd0);
    is_nan   = (exp_f == EXP_ONES) && (man_f != 52'd0);
    is_sat   = !is_zero && !is_nan && ((exp_f == EXP_ONES) || (e_unb >= SAT_E));
    special  = is_zero || is_nan || is_sat;
    rnd      = mag + {{(WR-1){1'b0}}, guard};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = special ? DONE : SHIFT;
      SHIFT: if (cnt == 6'd1) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      mag      <= '0;
      guard    <= 1'b0;
      sign_q   <= 1'b0;
      shl      <= 1'b0;
      shr      <= 1'b0;
      out_num  <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q   <= in_num[63];
          guard    <= 1'b0;
          cnt      <= cnt_load;
          shl      <= !sh[15] && (sh != 16'sd0);
          shr      <= sh[15];
          mag      <= WR'({1'b1, man_f});
          out_num  <= is_sat ? (in_num[63] ? SAT_NEG : SAT_POS) : '0;
          overflow <= is_sat;
          invalid  <= is_nan;
        end
        SHIFT: begin
          // Right shifts keep only the most recent bit dropped as the guard.
          if (shl)      mag <= mag << 1;
          else if (shr) {mag, guard} <= {1'b0, mag};
          cnt <= cnt - 6'd1;
        end
        ROUND: begin
          if (!sign_q && (rnd >= POS_LIM)) begin
            out_num  <= SAT_POS;
            overflow <= 1'b1;
          end else begin
            out_num <= sign_q ? -$signed(rnd[W-1:0]) : $signed(rnd[W-1:0]);
          end
        end
        DONE: if (out_ready) begin
          out_num  <= '0;
          overflow <= 1'b0;
          invalid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_from_double.sv
// Randomised and directed bench for from_double against a real-arithmetic reference model.
module tb_from_double;
  localparam int W = 48;

  logic                clk, rst, in_valid, in_ready, out_valid, out_ready, overflow, invalid;
  logic [63:0]         in_num;
  logic signed [W-1:0] out_num;
  logic [1:0]          state_dbg;

  int errors = 0;
  int checks = 0;

  logic [W+1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           neg_n = 0;
  bit           seen = 0;

  from_double dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
    .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
    .overflow(overflow), .invalid(invalid), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Result packed as {overflow, invalid, out_num}.
  function automatic logic [W+1:0] model(input logic [63:0] d);
    real          x, a;
    longint       q;
    logic [W-1:0] v;
    logic [10:0]  ex;
    ex = d[62:52];
    if (ex == 11'd0) return '0;
    if (ex == 11'd2047) begin
      if (d[51:0] != 52'd0) return {2'b01, {W{1'b0}}};
      return {2'b10, d[63] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}};
    end
    x = $bitstoreal(d);
    if (x >= 2147483648.0 || x <= -2147483648.0)
      return {2'b10, d[63] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}};
    a = (x < 0.0 ? -x : x) * 65536.0;
    q = longint'($floor(a + 0.5));
    if (!d[63] && q > 64'sd140737488355327) return {2'b10, 1'b0, {(W-1){1'b1}}};
    if (d[63]) q = -q;
    v = q[W-1:0];
    return {2'b00, v};
  endfunction

  function automatic int model_lat(input logic [63:0] d);
    int e, s;
    if (d[62:52] == 11'd0 || d[62:52] == 11'd2047) return 1;
    e = int'(d[62:52]) - 1023;
    if (e >= 31) return 1;
    s = e + 16 - 52;
    if (s < 0) s = -s;
    if (s > 55) s = 55;
    if (s == 0) s = 1;
    return s + 2;
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (out_valid !== 1'b0 || out_num !== '0 || overflow !== 1'b0 || invalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b num=%h ovf=%b inv=%b, want all zero",
                 out_valid, out_num, overflow, invalid);
      end
      exp_q.delete(); lat_q.delete(); acc_q.delete(); seen = 0;
    end else begin
      neg_n++;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 num=%h, want no result pending", out_num);
        end else begin
          if (!seen) begin
            seen = 1;
            checks++;
            if (neg_n - acc_q[0] != lat_q[0]) begin
              errors++;
              $display("FAIL latency: got %0d, want %0d", neg_n - acc_q[0], lat_q[0]);
            end
          end
          if ({overflow, invalid, out_num} !== exp_q[0]) begin
            errors++;
            $display("FAIL result: got ovf=%b inv=%b num=%h, want ovf=%b inv=%b num=%h",
                     overflow, invalid, out_num, exp_q[0][W+1], exp_q[0][W], exp_q[0][W-1:0]);
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_while_done: got in_ready=%b, want 0", in_ready);
          end
          if (out_ready) begin
            void'(exp_q.pop_front()); void'(lat_q.pop_front()); void'(acc_q.pop_front());
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_num));
        lat_q.push_back(model_lat(in_num));
        acc_q.push_back(neg_n);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] v, input int hold);
    int budget;
    budget = 0;
    while (!in_ready && budget < 200) begin @(posedge clk); #1; budget++; end
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_num    = v;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_num    = {$urandom, $urandom};
    budget = 0;
    while (!out_valid && budget < 100) begin
      in_num = {$urandom, $urandom};
      @(posedge clk); #1; budget++;
    end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL timeout: no out_valid for %h within 100 cycles", v);
    end
    // A second operand offered while the result waits must be ignored.
    for (int i = 0; i < hold; i++) begin
      in_valid = (i < hold - 1);
      in_num   = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pin(input string name, input logic [63:0] d, input logic [W+1:0] want, input int lat);
    checks++;
    if (model(d) !== want || model_lat(d) != lat) begin
      errors++;
      $display("FAIL pin_%s: got %h lat %0d, want %h lat %0d", name, model(d), model_lat(d), want, lat);
    end
  endtask

  function automatic logic [63:0] rand_double();
    logic [63:0] d;
    int          e;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: d[62:52] = 11'd0;
      1: d[62:52] = 11'd2047;
      2: ;
      default: begin
        e = $urandom_range(0, 95) - 60;
        d[62:52] = 11'(1023 + e);
      end
    endcase
    return d;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_num = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b, want 1", in_ready);
    end

    pin("one",    64'h3FF0000000000000, {2'b00, 48'h000000010000}, 38);
    pin("m2p5",   64'hC004000000000000, {2'b00, 48'hFFFFFFFD8000}, 37);
    pin("tie",    64'h3EE0000000000000, {2'b00, 48'h000000000001}, 55);
    pin("quart",  64'h3ED0000000000000, {2'b00, 48'h000000000000}, 56);
    pin("inf",    64'h7FF0000000000000, {2'b10, 48'h7FFFFFFFFFFF}, 1);
    pin("nan",    64'h7FF8000000000000, {2'b01, 48'h000000000000}, 1);
    pin("two31",  64'h41E0000000000000, {2'b10, 48'h7FFFFFFFFFFF}, 1);

    send(64'h3FF0000000000000, 0);
    send(64'hC004000000000000, 0);
    send(64'h3EE0000000000000, 0);
    send(64'h3ED0000000000000, 0);
    send(64'h7FF0000000000000, 0);
    send(64'hFFF0000000000000, 0);
    send(64'h7FF8000000000000, 0);
    send(64'h41E0000000000000, 0);
    send(64'hC1E0000000000000, 0);
    send(64'h41DFFFFFFFFFFFFF, 0);
    send(64'hC1DFFFFFFFFFFFFF, 0);
    send(64'h0000000000000000, 0);
    send(64'h8000000000000001, 0);
    send(64'h4240000000000000, 0);
    send(64'h3FF0000000000000, 10);

    // Abort a conversion mid-shift.
    in_valid = 1'b1; in_num = 64'h3FF0000000000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_num !== '0 || overflow !== 1'b0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b num=%h, want 0 0", out_valid, out_num);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_abort: got %b, want 1", in_ready);
    end
    repeat (60) @(posedge clk);
    #1;
    send(64'h4008000000000000, 0);

    for (int i = 0; i < 40; i++) send(rand_double(), $urandom_range(0, 3));

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d results pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/from_double.md
FROM_DOUBLE -- requirements
Module: from_double

Interface
REQ-001 SHALL have parameter N_BITS_INT, default 32, integer bits of the fixed-point result including sign.
REQ-002 SHALL have parameter N_BITS_FRAC, default 16, fraction bits of the result; W = N_BITS_INT+N_BITS_FRAC.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  in_num holds an operand.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-007 SHALL have port in_num  input  double (64)  IEEE-754 binary64 operand {sign, exponent[10:0], mantissa[51:0]}.
REQ-008 SHALL have port out_valid  output  1  out_num/flags valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_num  output  signed W  two's-complement result, N_BITS_FRAC fraction bits.
REQ-011 SHALL have port overflow  output  1  result saturated (|value| out of range or infinity).
REQ-012 SHALL have port invalid  output  1  operand was NaN.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, ROUND, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept when in_valid && in_ready; operand captured that edge; IDLE -> SHIFT, or -> DONE for special cases.
REQ-015 Special cases go straight to DONE: exponent 0 (zero/subnormal) -> 0; exponent 2047 with mantissa != 0 -> 0, invalid=1; exponent 2047 mantissa 0 -> saturate, overflow=1.
REQ-016 With e = exponent-1023: e >= N_BITS_INT-1 SHALL saturate to 2^(W-1)-1 (sign 0) or -2^(W-1) (sign 1), overflow=1, direct to DONE.
REQ-017 Otherwise significand S = {1, mantissa} (53 bits); shift count s = e+N_BITS_FRAC-52; working register width max(53,W)+2.
REQ-018 SHIFT SHALL move S exactly one position per cycle: left if s>0, right if s<0, |s| cycles, clamped to 55; s=0 spends one SHIFT cycle with no move.
REQ-019 Right shifts SHALL keep the last bit shifted out as guard bit; bits below guard discarded.
REQ-020 ROUND (one cycle): magnitude += guard (round-to-nearest, ties away from zero); negate if sign=1.
REQ-021 If rounded positive magnitude equals 2^(W-1): saturate to 2^(W-1)-1, overflow=1; -2^(W-1) is representable, no overflow.
REQ-022 Latency: accept at edge 0 -> out_valid high after edge |s|+2 (max(|s|,1)+2 for s=0); special/saturated cases: out_valid after edge 1.
REQ-023 DONE: out_valid=1; out_num, overflow, invalid stable until out_ready sampled high, then -> IDLE same edge.
REQ-024 No new operand accepted before DONE handshake completes; in_num changes during SHIFT/ROUND ignored.
REQ-025 overflow and invalid SHALL be meaningful only while out_valid=1, and are cleared on leaving DONE.

Reset
REQ-026 rst low SHALL immediately force IDLE, out_valid=0, out_num=0, overflow=0, invalid=0, in_ready=1 after release, regardless of state.
REQ-027 Reset mid-SHIFT/ROUND/DONE SHALL discard the operation; no result emitted after release.

Structure
REQ-028 double typedef and bias constant 1023, exponent all-ones 2047 SHALL come from shared package fp_double.
REQ-029 FSM state enum SHALL be local to the module.
REQ-030 Single module; no sub-module and no RAM.

Verification
REQ-031 1.0 (0x3FF0000000000000), out_ready=1 -> out_num 0x000000010000, s=-36, out_valid after edge 38, flags 0.
REQ-032 -2.5 (0xC004000000000000) -> out_num 0xFFFFFFFD8000 (-163840), flags 0.
REQ-033 2^-17 (0x3EE0000000000000) -> out_num 1 (tie rounds away); 2^-18 (0x3ED0000000000000) -> 0.
REQ-034 +Inf (0x7FF0000000000000) -> 0x7FFFFFFFFFFF, overflow=1, out_valid after edge 1; NaN (0x7FF8000000000000) -> 0, invalid=1; 2^31 (0x41E0000000000000) -> 0x7FFFFFFFFFFF, overflow=1.
REQ-035 1.0 with out_ready held low 10 cycles after out_valid -> out_num held, in_ready=0, second in_valid ignored; completes on out_ready=1.
REQ-036 rst low at SHIFT cycle 5 of 1.0 -> outputs zero immediately, IDLE after release, no out_valid for that operand; next operand 3.0 -> 0x000000030000.
